// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receiving end of a multiplexed 4-digit, active-low 7-segment display bus.
// Follows the anode scan, waits for each digit's segment pattern to settle,
// decodes the pattern back to BCD and publishes a coherent 4-digit frame once
// every digit has been captured. Also flags unrecognised patterns, illegal
// anode codes and a stalled scan.
//
// Parameters
//   SETTLE_CYCLES  : cycles ANODE/SEG must hold unchanged before sampling (1..255)
//   TIMEOUT_CYCLES : cycles without a capture before scan_lost asserts
//   TIMEOUT_W      : width of the timeout counter (2**TIMEOUT_W > TIMEOUT_CYCLES)
//
// Ports
//   MCLK          in   system clock, rising edge
//   RESET         in   asynchronous active-high reset
//   ANODE[3:0]    in   digit select, active-low, bit3 = leftmost digit
//   SEG[6:0]      in   segments a..g, active-low, SEG[0] = a
//   digit3..0     out  committed BCD value per digit (4'hF blank, 4'hE invalid)
//   digit_valid   out  per digit: last committed pattern was recognised
//   blank_mask    out  per digit: last committed pattern was all segments off
//   frame_done    out  one-cycle pulse when a new frame is committed
//   error         out  one-cycle pulse on bad pattern or illegal anode code
//   scan_lost     out  level, scan activity has timed out
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic [3:0] ANODE,
    input  logic [6:0] SEG,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] digit_valid,
    output logic [3:0] blank_mask,
    output logic       frame_done,
    output logic       error,
    output logic       scan_lost
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX     = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Exactly one anode driven (one bit low).
    function automatic logic anode_legal(input logic [3:0] a);
        logic ok;
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Digit slot addressed by a legal anode code.
    function automatic logic [1:0] anode_index(input logic [3:0] a);
        logic [1:0] idx;
        case (a)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Returns {valid, blank, value[3:0]} for an active-low segment pattern.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b1000000: r = {2'b10, 4'd0};
            7'b1111001: r = {2'b10, 4'd1};
            7'b0100100: r = {2'b10, 4'd2};
            7'b0110000: r = {2'b10, 4'd3};
            7'b0011001: r = {2'b10, 4'd4};
            7'b0010010: r = {2'b10, 4'd5};
            7'b0000010: r = {2'b10, 4'd6};
            7'b1111000: r = {2'b10, 4'd7};
            7'b0000000: r = {2'b10, 4'd8};
            7'b0010000: r = {2'b10, 4'd9};
            7'b1111111: r = {2'b11, 4'hF};
            default:    r = {2'b00, 4'hE};
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Stage p0/p1: two-flop input synchronizer
    // -------------------------------------------------------------------------
    logic [3:0] anode_p0, anode_p1;
    logic [6:0] seg_p0, seg_p1;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            anode_p0 <= 4'hF;
            anode_p1 <= 4'hF;
            seg_p0   <= 7'h7F;
            seg_p1   <= 7'h7F;
        end else begin
            anode_p0 <= ANODE;
            anode_p1 <= anode_p0;
            seg_p0   <= SEG;
            seg_p1   <= seg_p0;
        end
    end

    logic an_legal;
    logic an_illegal;
    logic illegal_q;

    assign an_legal   = anode_legal(anode_p1);
    assign an_illegal = !an_legal && (anode_p1 != 4'hF);

    // -------------------------------------------------------------------------
    // Scan-tracking FSM
    // -------------------------------------------------------------------------
    state_t     state, state_nx;
    logic [3:0] lat_anode;
    logic [6:0] lat_seg;
    logic [7:0] settle_cnt;
    logic       latch_en;
    logic       cnt_inc;
    logic       capture;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            lat_anode  <= 4'hF;
            lat_seg    <= 7'h7F;
            settle_cnt <= 8'd0;
            illegal_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            illegal_q <= an_illegal;
            if (latch_en) begin
                lat_anode  <= anode_p1;
                lat_seg    <= seg_p1;
                settle_cnt <= 8'd0;
            end else if (cnt_inc) begin
                settle_cnt <= settle_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        latch_en = 1'b0;
        cnt_inc  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (an_legal) begin
                    latch_en = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (!an_legal) begin
                    state_nx = IDLE;
                end else if ((anode_p1 != lat_anode) || (seg_p1 != lat_seg)) begin
                    // Any movement restarts the settle window on the new value.
                    latch_en = 1'b1;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nx = CAPTURE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CAPTURE: begin
                capture  = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                // SEG is ignored here; only an anode change ends the digit.
                if (anode_p1 != lat_anode) begin
                    if (an_legal) begin
                        latch_en = 1'b1;
                        state_nx = SETTLE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture into shadow slots and frame commit
    // -------------------------------------------------------------------------
    logic [5:0]      cap_dec;
    logic [1:0]      cap_idx;
    logic [3:0]      cap_bit;
    logic [3:0][3:0] shd_val, shd_val_nx;
    logic [3:0]      shd_vld, shd_vld_nx;
    logic [3:0]      shd_blank, shd_blank_nx;
    logic [3:0]      cap_mask, cap_mask_nx;
    logic            commit;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic            tmo_hit;

    assign cap_dec = seg_decode(lat_seg);
    assign cap_idx = anode_index(lat_anode);
    assign cap_bit = capture ? (4'b0001 << cap_idx) : 4'b0000;
    assign commit  = (cap_mask == 4'hF);
    assign tmo_hit = !capture && (tmo_cnt == TMO_LAST);

    // Commit reads the post-capture shadow so a same-cycle capture is included.
    always_comb begin
        shd_val_nx   = shd_val;
        shd_vld_nx   = shd_vld;
        shd_blank_nx = shd_blank;
        if (capture) begin
            shd_val_nx[cap_idx]   = cap_dec[3:0];
            shd_vld_nx[cap_idx]   = cap_dec[5];
            shd_blank_nx[cap_idx] = cap_dec[4];
        end
    end

    always_comb begin
        cap_mask_nx = cap_mask | cap_bit;
        if (commit || tmo_hit) begin
            cap_mask_nx = cap_bit;
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            shd_val   <= '0;
            shd_vld   <= 4'h0;
            shd_blank <= 4'h0;
            cap_mask  <= 4'h0;
        end else begin
            shd_val   <= shd_val_nx;
            shd_vld   <= shd_vld_nx;
            shd_blank <= shd_blank_nx;
            cap_mask  <= cap_mask_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Timeout watchdog (saturating)
    // -------------------------------------------------------------------------
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt   <= '0;
            scan_lost <= 1'b0;
        end else if (capture) begin
            tmo_cnt   <= '0;
            scan_lost <= 1'b0;
        end else begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
            end
            if (tmo_hit) begin
                scan_lost <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            digit3      <= 4'hF;
            digit2      <= 4'hF;
            digit1      <= 4'hF;
            digit0      <= 4'hF;
            digit_valid <= 4'h0;
            blank_mask  <= 4'hF;
            frame_done  <= 1'b0;
            error       <= 1'b0;
        end else begin
            frame_done <= commit;
            // Illegal anode codes report once per entry, not every cycle held.
            error      <= (capture && !cap_dec[5]) || (an_illegal && !illegal_q);
            if (commit) begin
                digit3      <= shd_val_nx[3];
                digit2      <= shd_val_nx[2];
                digit1      <= shd_val_nx[1];
                digit0      <= shd_val_nx[0];
                digit_valid <= shd_vld_nx;
                blank_mask  <= shd_blank_nx;
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 4-digit 7-segment interface driven onto ANODE/SEG.
- Tracks the active-low anode scan and waits for each digit's segment pattern to settle.
- Decodes each pattern back to a BCD digit and publishes a coherent 4-digit frame.
- Used as an in-fabric display monitor and self-check: captures displayed time, stopwatch and score values, and detects blanked (blinking) digits.

Parameters:
- SETTLE_CYCLES, 4: MCLK cycles that ANODE and SEG must hold unchanged before a digit is sampled (range 1..255).
- TIMEOUT_CYCLES, 1000000: MCLK cycles without a valid anode change before scan_lost asserts.
- TIMEOUT_W, 20: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- MCLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ANODE  input  4  digit select, active-low; bit3 is the leftmost digit.
- SEG  input  7  segments, active-low; SEG[0]=a, SEG[1]=b, … SEG[6]=g.
- digit3, digit2, digit1, digit0  output  4 each  committed BCD value per digit; 4'hF means blank.
- digit_valid  output  4  per digit: 1 means the last committed pattern was recognized (0-9 or blank).
- blank_mask  output  4  per digit: 1 means the last committed pattern was all segments off.
- frame_done  output  1  one-cycle pulse when a new frame is committed.
- error  output  1  one-cycle pulse on an unrecognized pattern or an illegal anode code.
- scan_lost  output  1  level; scan activity has timed out.

Behaviour:
- Reset values:
  - digit3..0 = 4'hF; digit_valid = 0; blank_mask = 4'hF; frame_done = 0; error = 0; scan_lost = 0.
  - FSM = IDLE; shadow registers cleared; captured mask = 0; counters = 0.
- Inputs are registered twice (2-flop synchronizer) before use, adding 2 cycles of input latency.
- Legal anode codes are exactly one bit low: 1110, 1101, 1011, 0111.
  - 1111 (all off) is idle and is not an error.
  - Any other code pulses error once per entry and forces IDLE.
- Decode table (SEG[6:0], active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111 → 4'hF
  - anything else → invalid: value 4'hE, valid=0, error pulse.
- FSM:
  - IDLE: on a legal anode code, latch ANODE/SEG, clear the settle counter, go to SETTLE.
  - SETTLE:
    - If ANODE or SEG differs from the latched value, relatch and restart the count.
    - If ANODE becomes illegal or 1111, go to IDLE.
    - When the count reaches SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE (1 cycle):
    - Write the decoded value, valid and blank flags into the shadow slot for that digit.
    - Set the captured-mask bit; pulse error if the pattern is invalid.
    - Go to HOLD.
  - HOLD: stay while ANODE is unchanged (SEG changes here are ignored); on any ANODE change go to IDLE-equivalent handling in the same cycle, i.e. a new legal code enters SETTLE directly.
- Frame commit:
  - In the cycle after the captured mask becomes 4'hF, copy all shadow slots to the outputs, pulse frame_done, and clear the mask.
  - If a digit is captured again before the mask is full, its shadow slot is overwritten and the mask is unchanged.
- Timeout:
  - The timeout counter resets on every CAPTURE.
  - When it reaches TIMEOUT_CYCLES, scan_lost = 1 and the captured mask clears; outputs retain their last frame.
  - scan_lost clears on the next CAPTURE.
  - The counter saturates and does not wrap.
- Simultaneous events:
  - A capture and a mask-full commit in the same cycle: the commit uses the post-capture shadow.
  - error and frame_done may pulse in the same cycle.
- RESET mid-frame immediately restores all reset values; a partially captured frame is discarded.

Test Plan:
- Clean scan: ANODE cycles 0111, 1011, 1101, 1110 for 16 cycles each, with SEG = 0010000, 0110000, 1111001, 0100100 (9, 3, 1, 2).
  - Required: frame_done pulses once per sweep; digit3..0 = 9, 3, 1, 2; digit_valid = 1111; blank_mask = 0000.
- Glitch rejection: SEG toggles every cycle for 3 cycles after an anode switch with SETTLE_CYCLES=4.
  - Required: no capture until SEG is stable for 4 cycles; the committed value equals the stable pattern.
- Blink: digit1 SEG = 1111111 in alternate sweeps.
  - Required: digit1 alternates between 4'hF (blank_mask[1]=1) and its value; the other digits are unchanged.
- Bad inputs: SEG = 1010101 on digit0.
  - Required: single error pulse; after commit, digit0 = 4'hE and digit_valid[0] = 0.
  - Separately, ANODE = 0011 → error pulse and no capture.
- Stall: ANODE held at 1111 for TIMEOUT_CYCLES (set to 100 in the bench).
  - Required: scan_lost = 1 at cycle 100 with outputs retained.
  - After a full sweep resumes: scan_lost clears at the first capture, and frame_done pulses after four new captures.
- Reset mid-frame: assert RESET after 2 captures.
  - Required: outputs return to reset values immediately; the next frame_done occurs only after 4 fresh captures.
